// File: rtl/uart_tx.sv
// 8N1 UART transmitter: valid/ready byte intake into a small circular FIFO,
// shifted out LSB first on a registered tx line.
module uart_tx #(
  parameter int CLKS_PER_BIT = 10,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       tx,
  output logic       busy_out
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [7:0]       r_shift;
  logic             r_tx;
  logic             r_ready;
  logic             r_busy;

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  state_t           w_state_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic [2:0]       w_idx_next;
  logic [7:0]       w_shift_next;
  logic             w_tx_next;
  logic             w_pop;
  logic             w_push;
  logic             w_bit_end;
  logic             w_fifo_nonempty;
  logic [PTR_W:0]   w_count_next;

  assign w_push          = valid_in && r_ready;
  assign w_bit_end       = (r_cnt == CNT_LAST);
  assign w_fifo_nonempty = (r_count != '0);

  // tx is computed for the next state so the line flop changes on the same
  // edge as the state, with no path from data_in to tx.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_idx_next   = r_idx;
    w_shift_next = r_shift;
    w_tx_next    = 1'b1;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fifo_nonempty) begin
          w_pop        = 1'b1;
          w_shift_next = r_mem[r_rd_ptr];
          w_cnt_next   = '0;
          w_state_next = S_START;
          w_tx_next    = 1'b0;
        end
      end
      S_START: begin
        w_tx_next = 1'b0;
        if (w_bit_end) begin
          w_cnt_next   = '0;
          w_idx_next   = '0;
          w_state_next = S_DATA;
          w_tx_next    = r_shift[0];
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_DATA: begin
        w_tx_next = r_shift[0];
        if (w_bit_end) begin
          w_cnt_next = '0;
          if (r_idx == 3'd7) begin
            w_state_next = S_STOP;
            w_tx_next    = 1'b1;
          end else begin
            w_shift_next = {1'b0, r_shift[7:1]};
            w_idx_next   = r_idx + 1'b1;
            w_tx_next    = r_shift[1];
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_STOP: begin
        w_tx_next = 1'b1;
        if (w_bit_end) begin
          w_cnt_next = '0;
          if (w_fifo_nonempty) begin
            w_pop        = 1'b1;
            w_shift_next = r_mem[r_rd_ptr];
            w_state_next = S_START;
            w_tx_next    = 1'b0;
          end else begin
            w_state_next = S_IDLE;
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + 1'b1;
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - 1'b1;
    end
  end

  // A queued byte always leaves IDLE on the next edge, so tracking the next
  // state alone also covers the FIFO-non-empty case.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_tx     <= 1'b1;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
      r_tx    <= w_tx_next;
      r_count <= w_count_next;
      r_ready <= (w_count_next != CNT_FULL);
      r_busy  <= (w_state_next != S_IDLE);
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data_in;
    end
    r_shift <= w_shift_next;
  end

  assign ready_out = r_ready;
  assign tx        = r_tx;
  assign busy_out  = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: three instances (CLKS_PER_BIT 10, 2, 16)
// with a sampling serial decoder that pops expected bytes per frame.
module tb_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] din0, din1, din2;
  logic       vld0, vld1, vld2;
  logic       rdy0, rdy1, rdy2;
  logic       tx0, tx1, tx2;
  logic       bsy0, bsy1, bsy2;

  uart_tx #(.CLKS_PER_BIT(10), .FIFO_DEPTH(4)) u_dut0 (
    .clk(clk), .rst(rst), .data_in(din0), .valid_in(vld0),
    .ready_out(rdy0), .tx(tx0), .busy_out(bsy0));
  uart_tx #(.CLKS_PER_BIT(2), .FIFO_DEPTH(4)) u_dut1 (
    .clk(clk), .rst(rst), .data_in(din1), .valid_in(vld1),
    .ready_out(rdy1), .tx(tx1), .busy_out(bsy1));
  uart_tx #(.CLKS_PER_BIT(16), .FIFO_DEPTH(4)) u_dut2 (
    .clk(clk), .rst(rst), .data_in(din2), .valid_in(vld2),
    .ready_out(rdy2), .tx(tx2), .busy_out(bsy2));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];

  int t_acc, t_b0, t_b1, bad;
  int t_fr [5];
  logic [7:0] d_fr;
  logic ok_fr;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic tx_of(input int idx);
    case (idx)
      0:       return tx0;
      1:       return tx1;
      default: return tx2;
    endcase
  endfunction

  task automatic drive(input int idx, input logic v, input logic [7:0] d);
    case (idx)
      0:       begin vld0 = v; din0 = d; end
      1:       begin vld1 = v; din1 = d; end
      default: begin vld2 = v; din2 = d; end
    endcase
  endtask

  task automatic expect_byte(input int idx, input logic [7:0] d);
    case (idx)
      0:       q0.push_back(d);
      1:       q1.push_back(d);
      default: q2.push_back(d);
    endcase
  endtask

  task automatic push(input int idx, input logic [7:0] d, output int t);
    @(negedge clk);
    drive(idx, 1'b1, d);
    @(posedge clk);
    #1;
    t = cyc;
    drive(idx, 1'b0, 8'h00);
    expect_byte(idx, d);
  endtask

  // Finds the next start bit, samples the full 10-bit frame once per cycle,
  // checks every bit is held for exactly cpb cycles and pops the scoreboard.
  task automatic get_frame(input int idx, input int cpb, output int t0,
                           output logic [7:0] d, output logic ok);
    logic smp [160];
    logic [7:0] exp_b;
    int n, nbad, sz;
    ok = 1'b1;
    n = 0;
    t0 = 0;
    d = 8'h00;
    @(negedge clk);
    while (tx_of(idx) !== 1'b0) begin
      if (n >= 3000) begin
        check_eq("start_timeout", 1, 0);
        ok = 1'b0;
        return;
      end
      @(negedge clk);
      n++;
    end
    t0 = cyc;
    for (int s = 0; s < 10 * cpb; s++) begin
      if (s > 0) @(negedge clk);
      smp[s] = tx_of(idx);
    end
    nbad = 0;
    for (int b = 0; b < 10; b++)
      for (int k = 0; k < cpb; k++)
        if (smp[b * cpb + k] !== smp[b * cpb]) nbad++;
    check_eq("bit_hold", nbad, 0);
    check_eq("start_bit", smp[0], 0);
    check_eq("stop_bit", smp[9 * cpb], 1);
    for (int b = 0; b < 8; b++) d[b] = smp[(b + 1) * cpb];
    case (idx)
      0:       sz = q0.size();
      1:       sz = q1.size();
      default: sz = q2.size();
    endcase
    if (sz == 0) begin
      check_eq("sb_unexpected", d, 32'hFFFF_FFFF);
    end else begin
      case (idx)
        0:       exp_b = q0.pop_front();
        1:       exp_b = q1.pop_front();
        default: exp_b = q2.pop_front();
      endcase
      check_eq("sb_data", d, exp_b);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    vld0 = 1'b0; vld1 = 1'b0; vld2 = 1'b0;
    din0 = 8'h00; din1 = 8'h00; din2 = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_tx0", tx0, 1);
    check_eq("rst_ready0", rdy0, 1);
    check_eq("rst_busy0", bsy0, 0);
    check_eq("rst_tx1", tx1, 1);
    check_eq("rst_tx2", tx2, 1);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Single byte with busy duration
    fork
      begin
        push(0, 8'hA5, t_acc);
        get_frame(0, 10, t_fr[0], d_fr, ok_fr);
        check_eq("single_latency", t_fr[0] - t_acc, 1);
      end
      begin
        bad = 0;
        @(negedge clk);
        while (bsy0 !== 1'b1 && bad < 300) begin @(negedge clk); bad++; end
        t_b0 = cyc;
        while (bsy0 !== 1'b0 && bad < 600) begin @(negedge clk); bad++; end
        t_b1 = cyc;
        check_eq("busy_len", t_b1 - t_b0, 100);
      end
    join
    @(negedge clk);
    check_eq("single_idle_tx", tx0, 1);
    check_eq("single_idle_busy", bsy0, 0);

    // Three queued bytes back to back
    fork
      begin
        push(0, 8'h00, t_acc);
        push(0, 8'hFF, t_acc);
        push(0, 8'h3C, t_acc);
      end
      begin
        for (int i = 0; i < 3; i++) begin
          get_frame(0, 10, t_fr[i], d_fr, ok_fr);
          if (i > 0) check_eq("seq_pitch", t_fr[i] - t_fr[i-1], 100);
        end
      end
    join
    repeat (20) @(negedge clk);

    // Burst of eight with valid held; only five fit
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          check_eq("burst_ready", rdy0, (i < 5) ? 1 : 0);
          vld0 = 1'b1;
          din0 = 8'(i + 1);
          @(posedge clk);
          #1;
          if (i < 5) expect_byte(0, 8'(i + 1));
        end
        vld0 = 1'b0;
        @(negedge clk);
        check_eq("burst_full_ready", rdy0, 0);
      end
      begin
        for (int i = 0; i < 5; i++) begin
          get_frame(0, 10, t_fr[i], d_fr, ok_fr);
          if (i > 0) check_eq("burst_pitch", t_fr[i] - t_fr[i-1], 100);
        end
      end
    join
    @(negedge clk);
    check_eq("burst_end_busy", bsy0, 0);
    check_eq("burst_end_ready", rdy0, 1);
    check_eq("burst_sb_empty", q0.size(), 0);
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (tx0 !== 1'b1) bad++;
    end
    check_eq("burst_no_extra", bad, 0);

    // Reset during data bit 3 of 0x5A with a second byte queued
    push(0, 8'h5A, t_acc);
    push(0, 8'h77, t_acc);
    repeat (43) @(posedge clk);
    #2;
    check_eq("pre_rst_bit3", tx0, 1);
    check_eq("pre_rst_busy", bsy0, 1);
    rst = 1'b1;
    #1;
    check_eq("midrst_tx", tx0, 1);
    check_eq("midrst_ready", rdy0, 1);
    check_eq("midrst_busy", bsy0, 0);
    q0.delete();
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (150) begin
      @(negedge clk);
      if (tx0 !== 1'b1 || bsy0 !== 1'b0) bad++;
    end
    check_eq("post_rst_quiet", bad, 0);
    push(0, 8'hC3, t_acc);
    get_frame(0, 10, t_fr[0], d_fr, ok_fr);
    @(negedge clk);
    check_eq("post_rst_idle", bsy0, 0);

    // Bit-period sweep
    push(1, 8'h81, t_acc);
    get_frame(1, 2, t_fr[0], d_fr, ok_fr);
    check_eq("cpb2_latency", t_fr[0] - t_acc, 1);
    @(negedge clk);
    check_eq("cpb2_idle_tx", tx1, 1);
    check_eq("cpb2_idle_busy", bsy1, 0);

    push(2, 8'h81, t_acc);
    get_frame(2, 16, t_fr[0], d_fr, ok_fr);
    check_eq("cpb16_latency", t_fr[0] - t_acc, 1);
    @(negedge clk);
    check_eq("cpb16_idle_tx", tx2, 1);
    check_eq("cpb16_idle_busy", bsy2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
